wifi_reset_sequencer: RTL
=========================

Name: wifi_reset_sequencer

Overview:
- Avalon-MM slave that owns the WiFi module's active-low reset line.
- Generates a programmable reset-low pulse, then a programmable boot-wait window, and reports busy/done status.
- Raises an optional interrupt on completion.
- Replaces CPU bit-banging of the reset PIO. Sits on the HPS-to-FPGA lightweight bus beside the WiFi UART.

Parameters:
- CNT_W, 32, width of the pulse/boot counters and registers.
- PULSE_DEFAULT, 50000, reset value of PULSE_CYCLES (1 ms at 50 MHz).
- BOOT_DEFAULT, 25000000, reset value of BOOT_CYCLES (500 ms at 50 MHz).
- AUTO_START, 1, 1 = run one sequence automatically on leaving reset.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational from address, zero wait states.
- wifi_reset_n  out  1  reset line to the WiFi module; low = module held in reset.
- irq  out  1  completion interrupt, level.

Behaviour:
- Register map (write accepted on rising edge when chipselect=1 and write_n=0):
  - addr 0 CTRL. Write bit0 START, bit1 DONE_CLR (W1C), bit2 ABORT, bit3 IRQ_EN (RW). Read bit0 busy, bit1 done, bit2 wifi_reset_n, bit3 irq_en.
  - addr 1 PULSE_CYCLES, RW, CNT_W bits.
  - addr 2 BOOT_CYCLES, RW, CNT_W bits.
  - addr 3 COUNT, read-only, current down-counter value; writes ignored.
  - Unused readdata bits read 0.
- Reset values (while reset_n=0):
  - wifi_reset_n=1, irq=0, busy=0, done=0, irq_en=0.
  - PULSE_CYCLES=PULSE_DEFAULT, BOOT_CYCLES=BOOT_DEFAULT, count=0, state IDLE.
- FSM states: IDLE, PULSE, BOOT.
  - IDLE: wifi_reset_n=1, busy=0.
    - On START, at the accepting edge: state becomes PULSE and count loads max(PULSE_CYCLES,1)-1.
    - If AUTO_START=1: the first clk edge after reset_n deasserts behaves as a START.
  - PULSE: wifi_reset_n=0, busy=1, count decrements each cycle.
    - When count==0: if BOOT_CYCLES==0, go to IDLE and set done on that edge; else go to BOOT and load count=BOOT_CYCLES-1.
  - BOOT: wifi_reset_n=1, busy=1, count decrements each cycle.
    - When count==0: go to IDLE and set done.
- Timing contract:
  - After START is accepted at edge t, wifi_reset_n is low for exactly max(N,1) cycles, starting at edge t.
  - busy then stays high for exactly B further cycles, where N = PULSE_CYCLES and B = BOOT_CYCLES sampled at the respective state entry.
  - done rises on the same edge busy falls.
- wifi_reset_n is driven from a register (glitch-free). Combinational decode must not feed the pin.
- irq = done & irq_en, registered-free AND of two flops.
- Boundary rules:
  - START while busy: ignored; the running sequence is unaffected.
  - ABORT in any state: next edge goes to IDLE, wifi_reset_n=1, count=0, done unchanged.
  - START and ABORT in the same write: ABORT wins.
  - START from IDLE clears done on the accepting edge.
  - DONE_CLR on the same edge that done is being set: set wins.
  - PULSE_CYCLES/BOOT_CYCLES written while busy: stored immediately, but only used at the next state entry. The counter already loaded is not altered.
  - Counter never wraps: decrement is gated by count!=0.
  - reset_n asserted mid-sequence: immediate return to reset values; wifi_reset_n goes high asynchronously. AUTO_START then re-runs on release.

Test Plan:
- AUTO_START=1, PULSE_DEFAULT=4, BOOT_DEFAULT=6: release reset → wifi_reset_n low for exactly 4 cycles. busy stays high for 10 cycles total. done=1 and CTRL reads 0x6 afterwards.
- Write PULSE=0, BOOT=0, then CTRL=0x1 → wifi_reset_n low exactly 1 cycle, busy 1 cycle, done set on release edge. COUNT reads 0.
- Write IRQ_EN|START (0x9) with PULSE=3, BOOT=2 → irq rises 5 cycles after accept. Write CTRL=0xA (DONE_CLR, keep IRQ_EN) → irq and done fall next edge.
- During PULSE, write START again → timing unchanged. During BOOT, write CTRL=0x5 (START|ABORT) → IDLE next edge, wifi_reset_n=1, done stays 0.
- During PULSE with PULSE=8, write PULSE=2 → current pulse still 8 cycles. Next START gives a 2-cycle pulse. Reading addr1 returns 2 immediately.
- Assert reset_n low during PULSE → wifi_reset_n=1 within the same cycle (asynchronous). All registers read defaults after release with AUTO_START=0.

Source files
------------

// File: rtl/wifi_reset_sequencer.sv
// Avalon-MM reset sequencer for the WiFi module: drives a programmable reset-low
// pulse followed by a boot-wait window, with busy/done status and a completion irq.
module wifi_reset_sequencer #(
    parameter int CNT_W         = 32,
    parameter int PULSE_DEFAULT = 50000,
    parameter int BOOT_DEFAULT  = 25000000,
    parameter bit AUTO_START    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        wifi_reset_n,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, PULSE, BOOT} state_t;

    localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(PULSE_DEFAULT);
    localparam logic [CNT_W-1:0] BOOT_INIT  = CNT_W'(BOOT_DEFAULT);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           state, next_state;
    logic [CNT_W-1:0] pulse_cycles, boot_cycles, count, count_next, pulse_load;
    logic             done, irq_en, auto_pending, busy;
    logic             wr, ctrl_wr, start_req, abort_req, done_clr, set_done, start_ok;

    assign wr         = chipselect & ~write_n;
    assign ctrl_wr    = wr & (address == 2'd0);
    assign start_req  = auto_pending | (ctrl_wr & writedata[0]);
    assign abort_req  = ctrl_wr & writedata[2];
    assign done_clr   = ctrl_wr & writedata[1];
    assign pulse_load = (pulse_cycles == '0) ? '0 : pulse_cycles - ONE;
    assign busy       = (state != IDLE);
    assign irq        = done & irq_en;

    // The pin is registered from the next state so decode glitches never reach it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count        <= '0;
            wifi_reset_n <= 1'b1;
        end else begin
            state        <= next_state;
            count        <= count_next;
            wifi_reset_n <= (next_state != PULSE);
        end
    end

    always_comb begin
        next_state = state;
        count_next = count;
        set_done   = 1'b0;
        start_ok   = 1'b0;
        if (abort_req) begin
            next_state = IDLE;
            count_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        next_state = PULSE;
                        count_next = pulse_load;
                        start_ok   = 1'b1;
                    end
                end
                PULSE: begin
                    if (count == '0) begin
                        if (boot_cycles == '0) begin
                            next_state = IDLE;
                            set_done   = 1'b1;
                        end else begin
                            next_state = BOOT;
                            count_next = boot_cycles - ONE;
                        end
                    end else begin
                        count_next = count - ONE;
                    end
                end
                BOOT: begin
                    if (count == '0) begin
                        next_state = IDLE;
                        set_done   = 1'b1;
                    end else begin
                        count_next = count - ONE;
                    end
                end
                default: begin
                    next_state = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {28'd0, irq_en, wifi_reset_n, done, busy};
            2'd1:    readdata = 32'(pulse_cycles);
            2'd2:    readdata = 32'(boot_cycles);
            default: readdata = 32'(count);
        endcase
    end

    // A completing sequence sets done even if DONE_CLR arrives on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_cycles <= PULSE_INIT;
            boot_cycles  <= BOOT_INIT;
            irq_en       <= 1'b0;
            done         <= 1'b0;
            auto_pending <= AUTO_START;
        end else begin
            auto_pending <= 1'b0;
            if (ctrl_wr)
                irq_en <= writedata[3];
            if (wr && address == 2'd1)
                pulse_cycles <= writedata[CNT_W-1:0];
            if (wr && address == 2'd2)
                boot_cycles <= writedata[CNT_W-1:0];
            if (set_done)
                done <= 1'b1;
            else if (start_ok || done_clr)
                done <= 1'b0;
        end
    end

endmodule
